// File: rtl/median_pkg.sv
// ----------------------------------------------------------------------------
// median_pkg
// Shared definitions for the 3x3 median filter pipeline.
//   PKG_DATA_W     : pixel width, fixed at 8 to match the sorter stage
//   PKG_IMG_WIDTH  : default pixels per line
//   PKG_IMG_HEIGHT : default lines per frame
//   pixel_t        : pixel type shared by the window generator and the sorter
// ----------------------------------------------------------------------------
package median_pkg;

    localparam int PKG_DATA_W     = 8;
    localparam int PKG_IMG_WIDTH  = 640;
    localparam int PKG_IMG_HEIGHT = 480;

    typedef logic [PKG_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/median_window_column_gen_if.sv
// ----------------------------------------------------------------------------
// median_window_column_gen_if
// Bundles the raster pixel input stream and the vertical column output stream
// of the median window column generator.
//   pix_in / pix_valid / sof           : raster-order input pixel stream
//   col_top / col_mid / col_bot        : rows y-2, y-1, y at column x
//   col_valid / col_first / col_last   : column qualifier and line-edge flags
//   frame_done                         : pulse with the last column of a frame
// Modports:
//   master : pixel source / column sink (drives the input stream)
//   slave  : the column generator itself
// ----------------------------------------------------------------------------
interface median_window_column_gen_if;
    import median_pkg::*;

    pixel_t pix_in;
    logic   pix_valid;
    logic   sof;

    pixel_t col_top;
    pixel_t col_mid;
    pixel_t col_bot;
    logic   col_valid;
    logic   col_first;
    logic   col_last;
    logic   frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  col_top, col_mid, col_bot, col_valid, col_first, col_last, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output col_top, col_mid, col_bot, col_valid, col_first, col_last, frame_done
    );

endinterface

// File: rtl/median_line_buf.sv
// ----------------------------------------------------------------------------
// median_line_buf
// One image line held as a circular buffer of DEPTH words. Read and write share
// one address: the read is combinational and returns the word stored before
// this cycle's write lands at the clock edge, so the caller sees the old pixel
// of the previous line while the new pixel replaces it. Maps to a single-port
// distributed RAM or an SRL chain.
//   clk       : rising-edge clock
//   i_addr    : shared read/write address (column position)
//   i_wrEn    : write enable, one write per accepted pixel
//   i_wrData  : word to store at i_addr
//   o_rdData  : word currently stored at i_addr (pre-write value)
// ----------------------------------------------------------------------------
module median_line_buf
    import median_pkg::*;
#(
    parameter int DEPTH = PKG_IMG_WIDTH,
    parameter int WIDTH = PKG_DATA_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_wrData,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read gives the previous line's pixel in the accept cycle.
    assign o_rdData = r_mem[i_addr];

    // Storage is never cleared: rows that have not been refilled since reset
    // or start of frame are masked by the row gating in the column generator.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_addr] <= i_wrData;
        end
    end

endmodule

// File: rtl/median_window_column_gen.sv
// ----------------------------------------------------------------------------
// median_window_column_gen
// Front end of the 3x3 median filter. Takes a raster-order pixel stream and,
// one cycle after each accepted pixel, presents the vertical column
// (x, y-2), (x, y-1), (x, y) for the 3-input sorters. Two chained line
// buffers hold the previous two lines; column/row counters track position,
// flag the line edges and mark the final column of each frame.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : slave side of median_window_column_gen_if
//           (pix_in, pix_valid, sof in; col_top/mid/bot, col_valid,
//            col_first, col_last, frame_done out, all registered)
// ----------------------------------------------------------------------------
module median_window_column_gen
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = PKG_IMG_WIDTH,
    parameter int IMG_HEIGHT = PKG_IMG_HEIGHT,
    parameter int DATA_W     = PKG_DATA_W,
    parameter int X_W        = $clog2(IMG_WIDTH),
    parameter int Y_W        = $clog2(IMG_HEIGHT)
) (
    input  logic                      clk,
    input  logic                      rst,
    median_window_column_gen_if.slave bus
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0]    r_xCnt;
    logic [Y_W-1:0]    r_yCnt;
    logic [X_W-1:0]    w_xCur;
    logic [Y_W-1:0]    w_yCur;
    logic              w_accept;
    logic [DATA_W-1:0] w_lineOneRd;
    logic [DATA_W-1:0] w_lineTwoRd;

    pixel_t r_colTop;
    pixel_t r_colMid;
    pixel_t r_colBot;
    logic   r_colValid;
    logic   r_colFirst;
    logic   r_colLast;
    logic   r_frameDone;

    // A start-of-frame pixel is placed at (0,0) before it is used, so the
    // position seen by the buffers and the flags is the forced one.
    assign w_xCur   = bus.sof ? '0 : r_xCnt;
    assign w_yCur   = bus.sof ? '0 : r_yCnt;
    assign w_accept = bus.pix_valid & ~rst;

    // Line one holds row y-1; its outgoing pixel shifts into line two (row y-2).
    median_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_W),
        .AW    (X_W)
    ) u_lineOne (
        .clk      (clk),
        .i_addr   (w_xCur),
        .i_wrEn   (w_accept),
        .i_wrData (bus.pix_in),
        .o_rdData (w_lineOneRd)
    );

    median_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_W),
        .AW    (X_W)
    ) u_lineTwo (
        .clk      (clk),
        .i_addr   (w_xCur),
        .i_wrEn   (w_accept),
        .i_wrData (w_lineOneRd),
        .o_rdData (w_lineTwoRd)
    );

    // Position counters and the registered column outputs. Data and edge flags
    // update only on an accept and hold through gaps; col_valid and frame_done
    // are single-cycle qualifiers. Rows 0 and 1 only prime the line buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xCnt      <= '0;
            r_yCnt      <= '0;
            r_colTop    <= '0;
            r_colMid    <= '0;
            r_colBot    <= '0;
            r_colValid  <= 1'b0;
            r_colFirst  <= 1'b0;
            r_colLast   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_colValid  <= 1'b0;
            r_frameDone <= 1'b0;
            if (bus.pix_valid) begin
                r_colTop   <= w_lineTwoRd;
                r_colMid   <= w_lineOneRd;
                r_colBot   <= bus.pix_in;
                r_colValid <= (w_yCur >= Y_W'(2));
                r_colFirst <= (w_xCur == '0);
                r_colLast  <= (w_xCur == X_LAST);
                if (w_xCur == X_LAST) begin
                    r_xCnt <= '0;
                    if (w_yCur == Y_LAST) begin
                        r_yCnt      <= '0;
                        r_frameDone <= 1'b1;
                    end else begin
                        r_yCnt <= w_yCur + Y_W'(1);
                    end
                end else begin
                    r_xCnt <= w_xCur + X_W'(1);
                    r_yCnt <= w_yCur;
                end
            end
        end
    end

    assign bus.col_top    = r_colTop;
    assign bus.col_mid    = r_colMid;
    assign bus.col_bot    = r_colBot;
    assign bus.col_valid  = r_colValid;
    assign bus.col_first  = r_colFirst;
    assign bus.col_last   = r_colLast;
    assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_median_window_column_gen.sv
// ----------------------------------------------------------------------------
// tb_median_window_column_gen
// Self-checking bench for the median window column generator on a 4x4 image.
// Every driven cycle pushes one expected-output record to a scoreboard queue;
// a monitor pops one record per clock edge and compares it with the DUT.
// Expected records come from a hand-built vector table (frame 1, the all-0xFF
// frame and the gapped replay of frame 1) or from a whole-frame reference
// store (sof resync, mid-frame reset, gap cycles).
// ----------------------------------------------------------------------------
module tb_median_window_column_gen;
    import median_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic   vld;
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
        logic   first;
        logic   last;
        logic   fd;
        logic   zeroAll;
    } exp_t;

    typedef struct {
        pixel_t pix;
        exp_t   e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    median_window_column_gen_if bus();

    median_window_column_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t   sbq[$];
    exp_t   noExp;
    exp_t   mon;
    int     checks = 0;
    int     errors = 0;
    pixel_t hist [H][W];
    int     mx = 0;
    int     my = 0;

    // Compare one DUT value with its expected value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the whole current frame is kept by (row, column); a column is
    // read straight from the two rows above the incoming pixel.
    task automatic modelStep(input pixel_t pix, input logic vld, input logic sofIn,
                             input logic rstIn, output exp_t e);
        e = noExp;
        if (rstIn) begin
            mx        = 0;
            my        = 0;
            e.zeroAll = 1'b1;
        end else if (vld) begin
            if (sofIn) begin
                mx = 0;
                my = 0;
            end
            if (my >= 2) begin
                e.vld   = 1'b1;
                e.top   = hist[my-2][mx];
                e.mid   = hist[my-1][mx];
                e.bot   = pix;
                e.first = (mx == 0);
                e.last  = (mx == W - 1);
                e.fd    = (mx == W - 1) && (my == H - 1);
            end
            hist[my][mx] = pix;
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic applyStimulus(input pixel_t pix, input logic vld, input logic sofIn,
                                 input logic rstIn, input logic useTab, input exp_t tabExp);
        exp_t e;
        rst           = rstIn;
        bus.pix_in    = pix;
        bus.pix_valid = vld;
        bus.sof       = sofIn;
        modelStep(pix, vld, sofIn, rstIn, e);
        if (useTab) begin
            sbq.push_back(tabExp);
        end else begin
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pixel_t pix, input logic vld, input logic sofIn);
        applyStimulus(pix, vld, sofIn, 1'b0, 1'b0, noExp);
    endtask

    // One scoreboard record is retired per clock edge, sampled after the edge.
    always @(posedge clk) begin
        #2;
        if (sbq.size() == 0) begin
            checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            mon = sbq.pop_front();
            checkOutput("col_valid", bus.col_valid, mon.vld);
            checkOutput("frame_done", bus.frame_done, mon.fd);
            if (mon.vld) begin
                checkOutput("col_top", bus.col_top, mon.top);
                checkOutput("col_mid", bus.col_mid, mon.mid);
                checkOutput("col_bot", bus.col_bot, mon.bot);
                checkOutput("col_first", bus.col_first, mon.first);
                checkOutput("col_last", bus.col_last, mon.last);
            end
            if (mon.zeroAll) begin
                checkOutput("reset_col_top", bus.col_top, 32'd0);
                checkOutput("reset_col_mid", bus.col_mid, 32'd0);
                checkOutput("reset_col_bot", bus.col_bot, 32'd0);
                checkOutput("reset_col_first", bus.col_first, 32'd0);
                checkOutput("reset_col_last", bus.col_last, 32'd0);
            end
        end
    end

    initial begin
        vec_t tab  [W*H];
        vec_t ffTab[W*H];

        noExp = '{default: '0};

        // Frame 1 vectors: pixel p = y*4+x; columns appear from row 2 on.
        for (int p = 0; p < W*H; p++) begin
            tab[p].pix = 8'(p);
            tab[p].e   = noExp;
            if (p >= 2*W) begin
                tab[p].e.vld   = 1'b1;
                tab[p].e.top   = 8'(p - 2*W);
                tab[p].e.mid   = 8'(p - W);
                tab[p].e.bot   = 8'(p);
                tab[p].e.first = (p % W == 0);
                tab[p].e.last  = (p % W == W - 1);
                tab[p].e.fd    = (p == W*H - 1);
            end
        end

        // Frame 2 vectors: all 0xFF, nothing from frame 1 may show through.
        for (int p = 0; p < W*H; p++) begin
            ffTab[p].pix = 8'hFF;
            ffTab[p].e   = noExp;
            if (p >= 2*W) begin
                ffTab[p].e.vld   = 1'b1;
                ffTab[p].e.top   = 8'hFF;
                ffTab[p].e.mid   = 8'hFF;
                ffTab[p].e.bot   = 8'hFF;
                ffTab[p].e.first = (p % W == 0);
                ffTab[p].e.last  = (p % W == W - 1);
                ffTab[p].e.fd    = (p == W*H - 1);
            end
        end

        // Reset: every output must read 0.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, noExp);
        end

        // Frame 1, continuous stream.
        for (int p = 0; p < W*H; p++) begin
            applyStimulus(tab[p].pix, 1'b1, 1'b0, 1'b0, 1'b1, tab[p].e);
        end

        // Frame 2 of 0xFF following directly.
        for (int p = 0; p < W*H; p++) begin
            applyStimulus(ffTab[p].pix, 1'b1, 1'b0, 1'b0, 1'b1, ffTab[p].e);
        end

        // Frame 1 again with 1-3 idle cycles after every pixel.
        for (int p = 0; p < W*H; p++) begin
            applyStimulus(tab[p].pix, 1'b1, (p == 0), 1'b0, 1'b1, tab[p].e);
            repeat ($urandom_range(1, 3)) drive(8'h00, 1'b0, 1'b0);
        end

        // sof on the pixel at x=2 of row 3 restarts the frame there.
        for (int p = 0; p < 14; p++) begin
            drive(8'(8'h40 + p), 1'b1, 1'b0);
        end
        drive(8'h80, 1'b1, 1'b1);
        drive(8'h00, 1'b1 & 1'b0, 1'b1);
        for (int p = 1; p < 12; p++) begin
            drive(8'(8'h80 + p), 1'b1, 1'b0);
        end

        // Finish that frame, run into row 2, then a one-cycle reset.
        for (int p = 0; p < 14; p++) begin
            drive(8'(8'hA0 + p), 1'b1, 1'b0);
        end
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, noExp);
        for (int p = 0; p < 12; p++) begin
            drive(8'(8'hC0 + p), 1'b1, 1'b0);
        end

        drive(8'h00, 1'b0, 1'b0);
        #5;
        checkOutput("scoreboard_drain", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
